vend_ctrl_multi: RTL

//  Parametrised vending-machine controller: N products with per-item prices and stock counters.

---
 rtl/vm_pkg.sv | 31 +++
 rtl/vm_stock_bank.sv | 35 +++
 rtl/vend_ctrl_multi.sv | 156 +++++++++++++++
 3 files changed

// File: rtl/vm_pkg.sv
// Shared definitions for the multi-product vending controller.
// FSM state encoding, default product prices and the price-table lookup helper.
package vm_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_CREDIT = 2'd1,
    ST_CHANGE = 2'd2
  } vm_state_t;

  localparam int unsigned PRICE_TEA    = 10;
  localparam int unsigned PRICE_COKE   = 15;
  localparam int unsigned PRICE_COFFEE = 20;
  localparam int unsigned PRICE_MILK   = 25;

  localparam logic [31:0] DEFAULT_PRICES = {8'(PRICE_MILK), 8'(PRICE_COFFEE),
                                            8'(PRICE_COKE), 8'(PRICE_TEA)};

  // Extracts the cw-bit price of item idx from a packed table (item 0 in the LSBs).
  function automatic logic [31:0] price_at(input logic [255:0] prices, input int idx,
                                           input int cw);
    logic [255:0] s;
    logic [31:0]  r;
    s = prices >> (idx * cw);
    r = '0;
    for (int b = 0; b < 32; b++)
      if (b < cw) r[b] = s[b];
    return r;
  endfunction

endpackage

// File: rtl/vm_stock_bank.sv
// Per-item stock counters: decrement on a sale, refill to full on restock.
// A restock wins over a same-cycle sale of the same item; counters never wrap below zero.
module vm_stock_bank
  import vm_pkg::*;
#(
  parameter int NUM_ITEMS  = 4,
  parameter int STOCK_W    = 4,
  parameter int INIT_STOCK = 5,
  parameter int IDX_W      = 2
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 dec,
  input  logic [IDX_W-1:0]     dec_idx,
  input  logic                 restock,
  input  logic [IDX_W-1:0]     restock_idx,
  output logic [NUM_ITEMS-1:0] sold_out
);

  logic [STOCK_W-1:0] cnt [NUM_ITEMS];

  for (genvar i = 0; i < NUM_ITEMS; i++) begin : g_item
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)
        cnt[i] <= STOCK_W'(INIT_STOCK);
      else if (restock && restock_idx == IDX_W'(i))
        cnt[i] <= '1;
      else if (dec && dec_idx == IDX_W'(i) && cnt[i] != '0)
        cnt[i] <= cnt[i] - 1'b1;
    end

    assign sold_out[i] = (cnt[i] == '0);
  end

endmodule

// File: rtl/vend_ctrl_multi.sv
// Vending controller: coin credit accumulation, item selection, stock and change handshake.
//   state     | meaning
//   ST_IDLE   | no credit held
//   ST_CREDIT | credit > 0, accepting coins / selections / cancel
//   ST_CHANGE | change_amt offered to the dispenser, waiting for change_ready
module vend_ctrl_multi
  import vm_pkg::*;
#(
  parameter int NUM_ITEMS  = 4,
  parameter int CREDIT_W   = 8,
  parameter int MAX_CREDIT = 100,
  parameter int STOCK_W    = 4,
  parameter int INIT_STOCK = 5,
  parameter logic [NUM_ITEMS*CREDIT_W-1:0] PRICES = DEFAULT_PRICES,
  localparam int IDX_W = (NUM_ITEMS > 1) ? $clog2(NUM_ITEMS) : 1
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 coin_valid,
  input  logic [CREDIT_W-1:0]  coin_value,
  input  logic                 cancel,
  input  logic                 sel_valid,
  input  logic [IDX_W-1:0]     sel_idx,
  input  logic                 restock,
  input  logic [IDX_W-1:0]     restock_idx,
  input  logic                 change_ready,
  output logic [CREDIT_W-1:0]  credit,
  output logic                 coin_reject,
  output logic                 sel_deny,
  output logic                 vend_valid,
  output logic [IDX_W-1:0]     vend_idx,
  output logic                 change_valid,
  output logic [CREDIT_W-1:0]  change_amt,
  output logic [NUM_ITEMS-1:0] sold_out
);

  vm_state_t state_q, state_d;
  logic [CREDIT_W-1:0] credit_q, credit_d, amt_q, amt_d, sel_price, remainder;
  logic [IDX_W-1:0]    vidx_q, vidx_d;
  logic                rej_q, rej_d, deny_q, deny_d, vv_q, vv_d, cv_q, cv_d;
  logic                dec, sel_empty, sel_in_range, sel_ok, coin_ok;
  logic [CREDIT_W:0]   sum;
  logic [CREDIT_W-1:0] price_tab [NUM_ITEMS];

  for (genvar i = 0; i < NUM_ITEMS; i++) begin : g_price
    assign price_tab[i] = CREDIT_W'(price_at(256'(PRICES), i, CREDIT_W));
  end

  vm_stock_bank #(
    .NUM_ITEMS (NUM_ITEMS),
    .STOCK_W   (STOCK_W),
    .INIT_STOCK(INIT_STOCK),
    .IDX_W     (IDX_W)
  ) u_stock (
    .clk        (clk),
    .rst_n      (reset),
    .dec        (dec),
    .dec_idx    (sel_idx),
    .restock    (restock),
    .restock_idx(restock_idx),
    .sold_out   (sold_out)
  );

  // Out-of-range selections read as an empty, zero-priced slot.
  always_comb begin
    sel_price = '0;
    sel_empty = 1'b1;
    for (int i = 0; i < NUM_ITEMS; i++) begin
      if (sel_idx == IDX_W'(i)) begin
        sel_price = price_tab[i];
        sel_empty = sold_out[i];
      end
    end
  end

  assign sum          = {1'b0, credit_q} + {1'b0, coin_value};
  assign coin_ok      = (coin_value != '0) && (sum <= (CREDIT_W+1)'(MAX_CREDIT));
  assign sel_in_range = ({1'b0, sel_idx} < (IDX_W+1)'(NUM_ITEMS));
  assign sel_ok       = sel_in_range && !sel_empty && (credit_q >= sel_price);
  assign remainder    = credit_q - sel_price;

  always_comb begin
    state_d  = state_q;
    credit_d = credit_q;
    amt_d    = amt_q;
    vidx_d   = vidx_q;
    rej_d    = 1'b0;
    deny_d   = 1'b0;
    vv_d     = 1'b0;
    dec      = 1'b0;
    if (state_q == ST_CHANGE) begin
      rej_d  = coin_valid;
      deny_d = sel_valid;
      if (change_ready) begin
        credit_d = '0;
        amt_d    = '0;
        state_d  = ST_IDLE;
      end
    end else if (cancel && credit_q != '0) begin
      rej_d   = coin_valid;
      amt_d   = credit_q;
      state_d = ST_CHANGE;
    end else if (sel_valid) begin
      rej_d = coin_valid;
      if (sel_ok) begin
        vv_d     = 1'b1;
        vidx_d   = sel_idx;
        dec      = 1'b1;
        credit_d = remainder;
        amt_d    = remainder;
        state_d  = (remainder != '0) ? ST_CHANGE : ST_IDLE;
      end else begin
        deny_d = 1'b1;
      end
    end else if (coin_valid) begin
      if (coin_ok) begin
        credit_d = sum[CREDIT_W-1:0];
        state_d  = ST_CREDIT;
      end else begin
        rej_d = 1'b1;
      end
    end
    cv_d = (state_d == ST_CHANGE);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q  <= ST_IDLE;
      credit_q <= '0;
      amt_q    <= '0;
      vidx_q   <= '0;
      rej_q    <= 1'b0;
      deny_q   <= 1'b0;
      vv_q     <= 1'b0;
      cv_q     <= 1'b0;
    end else begin
      state_q  <= state_d;
      credit_q <= credit_d;
      amt_q    <= amt_d;
      vidx_q   <= vidx_d;
      rej_q    <= rej_d;
      deny_q   <= deny_d;
      vv_q     <= vv_d;
      cv_q     <= cv_d;
    end
  end

  assign credit       = credit_q;
  assign coin_reject  = rej_q;
  assign sel_deny     = deny_q;
  assign vend_valid   = vv_q;
  assign vend_idx     = vidx_q;
  assign change_valid = cv_q;
  assign change_amt   = amt_q;

endmodule
